// File: rtl/buf_xbar_pkg.sv
// Shared definitions for the packet-buffer crossbar controller: buffer
// ownership state encoding, request/response field widths and the constant
// fields used to pad each agent's request out to the full buffer request.
package buf_xbar_pkg;

    // Ownership state of one packet buffer, following the packet life cycle.
    typedef enum logic [2:0] {
        ST_FREE     = 3'd0,
        ST_SNOOP    = 3'd1,
        ST_FILT_RDY = 3'd2,
        ST_FILT     = 3'd3,
        ST_FWD_RDY  = 3'd4,
        ST_FWD      = 3'd5,
        ST_DROPPED  = 3'd6
    } buf_state_t;

    // Single-bit fields of the request and response bundles.
    localparam int WR_EN_W  = 1;  // wr_en
    localparam int CTRL_W   = 2;  // {reset_sig, rd_en}
    localparam int RD_VLD_W = 1;  // rd_data_vld

    // The snooper only writes, so its read-side controls are tied low.
    localparam logic [CTRL_W-1:0]  SN_CTRL_PAD = 2'b00;
    // CPU and forwarder only read, so the write enable is tied low
    // (write data and byte increment are zero-filled to their widths).
    localparam logic [WR_EN_W-1:0] WR_EN_PAD   = 1'b0;

endpackage

// File: rtl/buf_owner_fsm.sv
// Ownership state of a single packet buffer. The controller decodes the
// agent pointers into per-buffer strobes; this block applies them and
// exposes which agent, if any, currently owns the buffer.
module buf_owner_fsm
    import buf_xbar_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       acq_sn,
    input  logic       rel_sn,
    input  logic       acq_cpu,
    input  logic       acc_cpu,
    input  logic       rej_cpu,
    input  logic       acq_fwd,
    input  logic       skip_fwd,
    input  logic       rel_fwd,
    output buf_state_t state,
    output logic       own_sn,
    output logic       own_cpu,
    output logic       own_fwd
);

    // Advance the buffer through its life cycle; owner flags are registered
    // with the state so the datapath steering sees a clean decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FREE;
            own_sn  <= 1'b0;
            own_cpu <= 1'b0;
            own_fwd <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    if (acq_sn) begin
                        state  <= ST_SNOOP;
                        own_sn <= 1'b1;
                    end
                end
                ST_SNOOP: begin
                    if (rel_sn) begin
                        state  <= ST_FILT_RDY;
                        own_sn <= 1'b0;
                    end
                end
                ST_FILT_RDY: begin
                    if (acq_cpu) begin
                        state   <= ST_FILT;
                        own_cpu <= 1'b1;
                    end
                end
                ST_FILT: begin
                    // A reject wins over a simultaneous accept.
                    if (rej_cpu) begin
                        state   <= ST_DROPPED;
                        own_cpu <= 1'b0;
                    end else if (acc_cpu) begin
                        state   <= ST_FWD_RDY;
                        own_cpu <= 1'b0;
                    end
                end
                ST_FWD_RDY: begin
                    if (acq_fwd) begin
                        state   <= ST_FWD;
                        own_fwd <= 1'b1;
                    end
                end
                ST_FWD: begin
                    if (rel_fwd) begin
                        state   <= ST_FREE;
                        own_fwd <= 1'b0;
                    end
                end
                ST_DROPPED: begin
                    if (skip_fwd) begin
                        state <= ST_FREE;
                    end
                end
                default: begin
                    state   <= ST_FREE;
                    own_sn  <= 1'b0;
                    own_cpu <= 1'b0;
                    own_fwd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/buf_xbar_ctrl.sv
// Packet-buffer crossbar controller. Tracks ownership of N_BUFS buffers,
// hands them to snooper, CPU and forwarder in strict round-robin order so
// packet order is preserved, and steers each owner's traffic to its buffer.
// The datapath is purely combinational from the registered ownership state.
module buf_xbar_ctrl
    import buf_xbar_pkg::*;
#(
    parameter int N_BUFS     = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int INC_WIDTH  = 8,
    parameter int PLEN_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH+WR_EN_W+INC_WIDTH-1:0]             from_sn,
    input  logic [TAG_WIDTH-1:0]                                           reorder_tag_from_sn,
    input  logic                                                           sn_done,
    output logic                                                           sn_own,
    input  logic [ADDR_WIDTH+CTRL_W-1:0]                                   from_cpu,
    input  logic                                                           cpu_acc,
    input  logic                                                           cpu_rej,
    output logic                                                           cpu_own,
    output logic [DATA_WIDTH+RD_VLD_W+PLEN_WIDTH-1:0]                      to_cpu,
    output logic [TAG_WIDTH-1:0]                                           reorder_tag_to_cpu,
    input  logic [ADDR_WIDTH+CTRL_W-1:0]                                   from_fwd,
    input  logic                                                           fwd_done,
    output logic                                                           fwd_own,
    output logic [DATA_WIDTH+RD_VLD_W+PLEN_WIDTH-1:0]                      to_fwd,
    output logic [TAG_WIDTH-1:0]                                           reorder_tag_to_fwd,
    output logic [N_BUFS*(ADDR_WIDTH+DATA_WIDTH+WR_EN_W+INC_WIDTH+CTRL_W)-1:0] to_buf,
    output logic [N_BUFS*TAG_WIDTH-1:0]                                    reorder_tag_to_buf,
    input  logic [N_BUFS*(DATA_WIDTH+RD_VLD_W+PLEN_WIDTH)-1:0]             from_buf,
    input  logic [N_BUFS*TAG_WIDTH-1:0]                                    reorder_tag_from_buf,
    output logic [$clog2(N_BUFS+1)-1:0]                                    free_cnt
);

    localparam int REQ_W  = ADDR_WIDTH + DATA_WIDTH + WR_EN_W + INC_WIDTH + CTRL_W;
    localparam int HOST_W = ADDR_WIDTH + CTRL_W;
    localparam int RSP_W  = DATA_WIDTH + RD_VLD_W + PLEN_WIDTH;
    localparam int PTR_W  = $clog2(N_BUFS);
    localparam int CNT_W  = $clog2(N_BUFS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_BUFS - 1);

    buf_state_t          buf_state [N_BUFS];
    logic [N_BUFS-1:0]   is_sn;
    logic [N_BUFS-1:0]   is_cpu;
    logic [N_BUFS-1:0]   is_fwd;
    logic [RSP_W-1:0]    rsp [N_BUFS];
    logic [TAG_WIDTH-1:0] rsp_tag [N_BUFS];

    logic [PTR_W-1:0] sn_ptr;
    logic [PTR_W-1:0] cpu_ptr;
    logic [PTR_W-1:0] fwd_ptr;

    logic sn_acq;
    logic sn_rel;
    logic cpu_acq;
    logic cpu_rel;
    logic fwd_acq;
    logic fwd_skip;
    logic fwd_rel;
    logic to_free;

    logic [REQ_W-1:0] sn_req;
    logic [REQ_W-1:0] cpu_req;
    logic [REQ_W-1:0] fwd_req;

    // Round-robin pointer advance with wrap at any buffer count.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Acquire only from idle, release only while owning: an agent can never
    // release and re-acquire in the same cycle.
    assign sn_acq   = !sn_own  && (buf_state[sn_ptr]  == ST_FREE);
    assign sn_rel   =  sn_own  && sn_done;
    assign cpu_acq  = !cpu_own && (buf_state[cpu_ptr] == ST_FILT_RDY);
    assign cpu_rel  =  cpu_own && (cpu_acc || cpu_rej);
    assign fwd_acq  = !fwd_own && (buf_state[fwd_ptr] == ST_FWD_RDY);
    assign fwd_skip = !fwd_own && (buf_state[fwd_ptr] == ST_DROPPED);
    assign fwd_rel  =  fwd_own && fwd_done;
    assign to_free  = fwd_rel || fwd_skip;

    // Each agent's request widened to the full buffer request format.
    assign sn_req  = {from_sn, SN_CTRL_PAD};
    assign cpu_req = {from_cpu[HOST_W-1:CTRL_W], {DATA_WIDTH{1'b0}}, WR_EN_PAD,
                      {INC_WIDTH{1'b0}}, from_cpu[CTRL_W-1:0]};
    assign fwd_req = {from_fwd[HOST_W-1:CTRL_W], {DATA_WIDTH{1'b0}}, WR_EN_PAD,
                      {INC_WIDTH{1'b0}}, from_fwd[CTRL_W-1:0]};

    // Agent ownership flags, round-robin pointers and the free-buffer count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sn_own   <= 1'b0;
            cpu_own  <= 1'b0;
            fwd_own  <= 1'b0;
            sn_ptr   <= '0;
            cpu_ptr  <= '0;
            fwd_ptr  <= '0;
            free_cnt <= CNT_W'(N_BUFS);
        end else begin
            if (sn_acq) begin
                sn_own <= 1'b1;
            end else if (sn_rel) begin
                sn_own <= 1'b0;
                sn_ptr <= next_ptr(sn_ptr);
            end

            if (cpu_acq) begin
                cpu_own <= 1'b1;
            end else if (cpu_rel) begin
                cpu_own <= 1'b0;
                cpu_ptr <= next_ptr(cpu_ptr);
            end

            // A dropped packet is recycled without the forwarder taking it.
            if (fwd_acq) begin
                fwd_own <= 1'b1;
            end else if (fwd_rel) begin
                fwd_own <= 1'b0;
                fwd_ptr <= next_ptr(fwd_ptr);
            end else if (fwd_skip) begin
                fwd_ptr <= next_ptr(fwd_ptr);
            end

            // Only the snooper leaves FREE and only the forwarder enters it.
            case ({to_free, sn_acq})
                2'b10:   free_cnt <= free_cnt + 1'b1;
                2'b01:   free_cnt <= free_cnt - 1'b1;
                default: free_cnt <= free_cnt;
            endcase
        end
    end

    for (genvar i = 0; i < N_BUFS; i++) begin : g_buf
        localparam logic [PTR_W-1:0] IDX = PTR_W'(i);

        buf_owner_fsm u_owner (
            .clk      (clk),
            .rst      (rst),
            .acq_sn   (sn_acq   && (sn_ptr  == IDX)),
            .rel_sn   (sn_rel   && (sn_ptr  == IDX)),
            .acq_cpu  (cpu_acq  && (cpu_ptr == IDX)),
            .acc_cpu  (cpu_rel  && !cpu_rej && (cpu_ptr == IDX)),
            .rej_cpu  (cpu_rel  &&  cpu_rej && (cpu_ptr == IDX)),
            .acq_fwd  (fwd_acq  && (fwd_ptr == IDX)),
            .skip_fwd (fwd_skip && (fwd_ptr == IDX)),
            .rel_fwd  (fwd_rel  && (fwd_ptr == IDX)),
            .state    (buf_state[i]),
            .own_sn   (is_sn[i]),
            .own_cpu  (is_cpu[i]),
            .own_fwd  (is_fwd[i])
        );

        assign to_buf[i*REQ_W +: REQ_W] = is_sn[i]  ? sn_req  :
                                          is_cpu[i] ? cpu_req :
                                          is_fwd[i] ? fwd_req : '0;
        assign reorder_tag_to_buf[i*TAG_WIDTH +: TAG_WIDTH] =
            is_sn[i] ? reorder_tag_from_sn : '0;

        assign rsp[i]     = from_buf[i*RSP_W +: RSP_W];
        assign rsp_tag[i] = reorder_tag_from_buf[i*TAG_WIDTH +: TAG_WIDTH];
    end

    assign to_cpu             = cpu_own ? rsp[cpu_ptr]     : '0;
    assign reorder_tag_to_cpu = cpu_own ? rsp_tag[cpu_ptr] : '0;
    assign to_fwd             = fwd_own ? rsp[fwd_ptr]     : '0;
    assign reorder_tag_to_fwd = fwd_own ? rsp_tag[fwd_ptr] : '0;

endmodule

// File: tb/tb_buf_xbar_ctrl.sv
// Directed bench for buf_xbar_ctrl: a 4-buffer instance exercises the packet
// flow, drop skipping, full stall and reset; 3- and 2-buffer instances share
// the same stimulus and are checked for pointer wrap and reset.
module tb_buf_xbar_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int IW    = 8;
    localparam int PW    = 32;
    localparam int TW    = 6;
    localparam int REQ_W = AW + DW + 1 + IW + 2;
    localparam int RSP_W = DW + 1 + PW;

    typedef logic [511:0] v_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW+DW+1+IW-1:0] from_sn  = '0;
    logic [TW-1:0]         tag_sn   = '0;
    logic                  sn_done  = 1'b0;
    logic                  cpu_acc  = 1'b0;
    logic                  cpu_rej  = 1'b0;
    logic                  fwd_done = 1'b0;
    logic [AW+1:0]         from_cpu = '0;
    logic [AW+1:0]         from_fwd = '0;

    logic [4*RSP_W-1:0] fb4 = '0;
    logic [4*TW-1:0]    ftag4 = '0;
    logic [3*RSP_W-1:0] fb3 = '0;
    logic [3*TW-1:0]    ftag3 = '0;
    logic [2*RSP_W-1:0] fb2 = '0;
    logic [2*TW-1:0]    ftag2 = '0;

    logic sn_own4, cpu_own4, fwd_own4;
    logic sn_own3, cpu_own3, fwd_own3;
    logic sn_own2, cpu_own2, fwd_own2;
    logic [RSP_W-1:0] to_cpu4, to_fwd4, to_cpu3, to_fwd3, to_cpu2, to_fwd2;
    logic [TW-1:0] tcpu4, tfwd4, tcpu3, tfwd3, tcpu2, tfwd2;
    logic [4*REQ_W-1:0] to_buf4;
    logic [3*REQ_W-1:0] to_buf3;
    logic [2*REQ_W-1:0] to_buf2;
    logic [4*TW-1:0] tbuf4;
    logic [3*TW-1:0] tbuf3;
    logic [2*TW-1:0] tbuf2;
    logic [2:0] free4;
    logic [1:0] free3;
    logic [1:0] free2;

    int checks   = 0;
    int failures = 0;

    logic [REQ_W-1:0] sn_req_exp;
    logic [REQ_W-1:0] cpu_req_exp;
    logic [REQ_W-1:0] fwd_req_exp;

    buf_xbar_ctrl #(.N_BUFS(4)) u4 (
        .clk(clk), .rst(rst), .from_sn(from_sn), .reorder_tag_from_sn(tag_sn),
        .sn_done(sn_done), .sn_own(sn_own4), .from_cpu(from_cpu), .cpu_acc(cpu_acc),
        .cpu_rej(cpu_rej), .cpu_own(cpu_own4), .to_cpu(to_cpu4), .reorder_tag_to_cpu(tcpu4),
        .from_fwd(from_fwd), .fwd_done(fwd_done), .fwd_own(fwd_own4), .to_fwd(to_fwd4),
        .reorder_tag_to_fwd(tfwd4), .to_buf(to_buf4), .reorder_tag_to_buf(tbuf4),
        .from_buf(fb4), .reorder_tag_from_buf(ftag4), .free_cnt(free4)
    );

    buf_xbar_ctrl #(.N_BUFS(3)) u3 (
        .clk(clk), .rst(rst), .from_sn(from_sn), .reorder_tag_from_sn(tag_sn),
        .sn_done(sn_done), .sn_own(sn_own3), .from_cpu(from_cpu), .cpu_acc(cpu_acc),
        .cpu_rej(cpu_rej), .cpu_own(cpu_own3), .to_cpu(to_cpu3), .reorder_tag_to_cpu(tcpu3),
        .from_fwd(from_fwd), .fwd_done(fwd_done), .fwd_own(fwd_own3), .to_fwd(to_fwd3),
        .reorder_tag_to_fwd(tfwd3), .to_buf(to_buf3), .reorder_tag_to_buf(tbuf3),
        .from_buf(fb3), .reorder_tag_from_buf(ftag3), .free_cnt(free3)
    );

    buf_xbar_ctrl #(.N_BUFS(2)) u2 (
        .clk(clk), .rst(rst), .from_sn(from_sn), .reorder_tag_from_sn(tag_sn),
        .sn_done(sn_done), .sn_own(sn_own2), .from_cpu(from_cpu), .cpu_acc(cpu_acc),
        .cpu_rej(cpu_rej), .cpu_own(cpu_own2), .to_cpu(to_cpu2), .reorder_tag_to_cpu(tcpu2),
        .from_fwd(from_fwd), .fwd_done(fwd_done), .fwd_own(fwd_own2), .to_fwd(to_fwd2),
        .reorder_tag_to_fwd(tfwd2), .to_buf(to_buf2), .reorder_tag_to_buf(tbuf2),
        .from_buf(fb2), .reorder_tag_from_buf(ftag2), .free_cnt(free2)
    );

    always #5 clk = ~clk;

    function automatic logic [RSP_W-1:0] rsp_pat(input int i);
        return {64'hA5A5_0000_0000_0000 + 64'(i), 1'b1, 32'(100 + i)};
    endfunction

    function automatic v_t slice(input int i, input logic [REQ_W-1:0] r);
        return v_t'(r) << (i * REQ_W);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input v_t obs, input v_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_sn();
        sn_done = 1'b1; step(); sn_done = 1'b0; step();
    endtask

    task automatic pulse_acc();
        cpu_acc = 1'b1; step(); cpu_acc = 1'b0; step();
    endtask

    task automatic pulse_rej();
        cpu_rej = 1'b1; step(); cpu_rej = 1'b0; step();
    endtask

    initial begin
        from_sn  = {10'h155, 64'hDEAD_BEEF_0123_4567, 1'b1, 8'h08};
        tag_sn   = 6'h2A;
        from_cpu = {10'h0A5, 1'b0, 1'b1};
        from_fwd = {10'h3C3, 1'b1, 1'b1};
        sn_req_exp  = {10'h155, 64'hDEAD_BEEF_0123_4567, 1'b1, 8'h08, 2'b00};
        cpu_req_exp = {10'h0A5, 64'h0, 1'b0, 8'h00, 1'b0, 1'b1};
        fwd_req_exp = {10'h3C3, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            fb4[i*RSP_W +: RSP_W] = rsp_pat(i);
            ftag4[i*TW +: TW]     = TW'(i + 8);
        end

        // Reset and first acquire
        step(); step();
        chk("rst_free",   v_t'(free4),    v_t'(4));
        chk("rst_sn_own", v_t'(sn_own4),  v_t'(0));
        chk("rst_to_buf", v_t'(to_buf4),  v_t'(0));
        chk("rst_to_cpu", v_t'(to_cpu4),  v_t'(0));
        rst = 1'b0;
        step();
        chk("idle_sn_own", v_t'(sn_own4), v_t'(1));
        chk("idle_free",   v_t'(free4),   v_t'(3));
        chk("idle_to_buf", v_t'(to_buf4), slice(0, sn_req_exp));
        chk("idle_tag_buf", v_t'(tbuf4),  v_t'(6'h2A));

        // Single packet through CPU and forwarder
        sn_done = 1'b1; step(); sn_done = 1'b0;
        chk("pkt_sn_rel",   v_t'(sn_own4),  v_t'(0));
        chk("pkt_cpu_wait", v_t'(cpu_own4), v_t'(0));
        chk("pkt_buf_idle", v_t'(to_buf4),  v_t'(0));
        step();
        chk("pkt_cpu_own", v_t'(cpu_own4), v_t'(1));
        chk("pkt_sn_next", v_t'(sn_own4),  v_t'(1));
        chk("pkt_free",    v_t'(free4),    v_t'(2));
        chk("pkt_to_cpu",  v_t'(to_cpu4),  v_t'(rsp_pat(0)));
        chk("pkt_tag_cpu", v_t'(tcpu4),    v_t'(8));
        chk("pkt_to_buf",  v_t'(to_buf4),  slice(0, cpu_req_exp) | slice(1, sn_req_exp));
        chk("pkt_tag_buf", v_t'(tbuf4),    v_t'(6'h2A) << TW);
        cpu_acc = 1'b1; step(); cpu_acc = 1'b0;
        chk("acc_cpu_rel",  v_t'(cpu_own4), v_t'(0));
        chk("acc_fwd_wait", v_t'(fwd_own4), v_t'(0));
        step();
        chk("acc_fwd_own", v_t'(fwd_own4), v_t'(1));
        chk("acc_to_fwd",  v_t'(to_fwd4),  v_t'(rsp_pat(0)));
        chk("acc_to_cpu",  v_t'(to_cpu4),  v_t'(0));
        chk("acc_to_buf",  v_t'(to_buf4),  slice(0, fwd_req_exp) | slice(1, sn_req_exp));
        fwd_done = 1'b1; step(); fwd_done = 1'b0;
        chk("done_fwd_rel", v_t'(fwd_own4), v_t'(0));
        chk("done_free",    v_t'(free4),    v_t'(3));

        // Reset while buf1 is being written
        rst = 1'b1; step();
        chk("mid_rst_to_buf", v_t'(to_buf4),  v_t'(0));
        chk("mid_rst_tag",    v_t'(tbuf4),    v_t'(0));
        chk("mid_rst_free",   v_t'(free4),    v_t'(4));
        chk("mid_rst_sn_own", v_t'(sn_own4),  v_t'(0));
        chk("mid_rst_to_fwd", v_t'(to_fwd4),  v_t'(0));
        rst = 1'b0; step();
        chk("restart_ptr0", v_t'(to_buf4), slice(0, sn_req_exp));

        // Three packets, the second rejected
        pulse_sn();
        pulse_acc();
        chk("drop_fwd_buf0", v_t'(fwd_own4), v_t'(1));
        pulse_sn();
        chk("drop_cpu_buf1", v_t'(to_cpu4), v_t'(rsp_pat(1)));
        pulse_rej();
        chk("drop_cpu_rel", v_t'(cpu_own4), v_t'(0));
        pulse_sn();
        chk("drop_free0", v_t'(free4), v_t'(0));
        pulse_acc();
        fwd_done = 1'b1; step(); fwd_done = 1'b0;
        chk("drop_rel_own",  v_t'(fwd_own4), v_t'(0));
        chk("drop_rel_free", v_t'(free4),    v_t'(1));
        step();
        chk("drop_skip_own",  v_t'(fwd_own4), v_t'(0));
        chk("drop_skip_free", v_t'(free4),    v_t'(2));
        step();
        chk("drop_fwd2_own", v_t'(fwd_own4), v_t'(1));
        chk("drop_fwd2_rsp", v_t'(to_fwd4),  v_t'(rsp_pat(2)));
        chk("drop_fwd2_tag", v_t'(tfwd4),    v_t'(10));

        // Full: CPU holds buf0 while the snooper fills every buffer
        rst = 1'b1; step(); rst = 1'b0; step();
        pulse_sn(); pulse_sn(); pulse_sn(); pulse_sn();
        chk("full_stall", v_t'(sn_own4), v_t'(0));
        chk("full_free",  v_t'(free4),   v_t'(0));
        step();
        chk("full_stall2", v_t'(sn_own4), v_t'(0));
        pulse_acc();
        chk("full_fwd_own", v_t'(fwd_own4), v_t'(1));
        chk("full_cpu_own", v_t'(cpu_own4), v_t'(1));
        fwd_done = 1'b1; step(); fwd_done = 1'b0;
        chk("full_freed_cnt", v_t'(free4),   v_t'(1));
        chk("full_freed_sn",  v_t'(sn_own4), v_t'(0));
        step();
        chk("full_wrap_sn",   v_t'(sn_own4), v_t'(1));
        chk("full_wrap_free", v_t'(free4),   v_t'(0));
        chk("full_wrap_buf",  v_t'(to_buf4), slice(0, sn_req_exp) | slice(1, cpu_req_exp));

        // Accept and reject together on buf1 drop it
        cpu_acc = 1'b1; cpu_rej = 1'b1; step(); cpu_acc = 1'b0; cpu_rej = 1'b0;
        chk("both_rel", v_t'(cpu_own4), v_t'(0));
        step();
        chk("both_skip_own", v_t'(fwd_own4), v_t'(0));
        chk("both_skip_free", v_t'(free4),   v_t'(1));
        chk("both_cpu_next", v_t'(cpu_own4), v_t'(1));
        step();
        chk("both_no_fwd", v_t'(fwd_own4), v_t'(0));

        // Spurious forwarder done while idle
        fwd_done = 1'b1; step(); fwd_done = 1'b0;
        chk("spur_fwd_own", v_t'(fwd_own4), v_t'(0));
        chk("spur_free",    v_t'(free4),    v_t'(1));
        chk("spur_to_fwd",  v_t'(to_fwd4),  v_t'(0));
        chk("spur_sn_own",  v_t'(sn_own4),  v_t'(1));

        // Wrap and reset on 3- and 2-buffer instances
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("w3_sn_own", v_t'(sn_own3), v_t'(1));
        chk("w3_free",   v_t'(free3),   v_t'(2));
        chk("w2_sn_own", v_t'(sn_own2), v_t'(1));
        chk("w2_free",   v_t'(free2),   v_t'(1));
        pulse_sn();
        chk("w3_free_p1", v_t'(free3),    v_t'(1));
        chk("w2_free_p1", v_t'(free2),    v_t'(0));
        chk("w2_cpu_own", v_t'(cpu_own2), v_t'(1));
        pulse_sn();
        chk("w2_stall",   v_t'(sn_own2), v_t'(0));
        chk("w3_sn_buf2", v_t'(sn_own3), v_t'(1));
        chk("w3_free_p2", v_t'(free3),   v_t'(0));
        pulse_sn();
        chk("w3_stall",   v_t'(sn_own3), v_t'(0));
        chk("w2_ignore",  v_t'(sn_own2), v_t'(0));
        chk("w2_free_p3", v_t'(free2),   v_t'(0));
        pulse_acc();
        chk("w3_fwd_own", v_t'(fwd_own3), v_t'(1));
        chk("w2_fwd_own", v_t'(fwd_own2), v_t'(1));
        fwd_done = 1'b1; step(); fwd_done = 1'b0;
        chk("w3_freed", v_t'(free3), v_t'(1));
        chk("w2_freed", v_t'(free2), v_t'(1));
        step();
        chk("w3_wrap_sn",  v_t'(sn_own3), v_t'(1));
        chk("w2_wrap_sn",  v_t'(sn_own2), v_t'(1));
        chk("w3_wrap_buf", v_t'(to_buf3), slice(0, sn_req_exp) | slice(1, cpu_req_exp));
        chk("w2_wrap_buf", v_t'(to_buf2), slice(0, sn_req_exp) | slice(1, cpu_req_exp));
        rst = 1'b1; step();
        chk("w3_rst_buf",  v_t'(to_buf3), v_t'(0));
        chk("w2_rst_buf",  v_t'(to_buf2), v_t'(0));
        chk("w3_rst_free", v_t'(free3),   v_t'(3));
        chk("w2_rst_free", v_t'(free2),   v_t'(2));
        chk("w3_rst_own",  v_t'({sn_own3, cpu_own3, fwd_own3}), v_t'(0));
        chk("w2_rst_own",  v_t'({sn_own2, cpu_own2, fwd_own2}), v_t'(0));
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
